alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle sequencer for the 8-bit CPU's shift, rotate and multiply instructions, which the single-cycle `alu` cannot complete. It accepts one operation per START handshake and performs one bit-step per clock. It then returns an 8-bit result with a DONE pulse and a ZERO flag. It sits beside `alu`: the control unit steers SELECT-extended opcodes here and stalls the PC while BUSY is high.

## Interface
Parameters: none. The data width is fixed at 8.

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-low reset (RESET=0 sampled at a CLK edge resets)
- START  in  1  request; sampled only when BUSY=0 at the edge
- OPCODE  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 MUL, 101–111 illegal
- DATA1  in  8  value to shift or rotate; multiplicand
- DATA2  in  8  unsigned shift/rotate count; multiplier
- RESULT  out  8  last completed result, registered; changes only on the DONE edge
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle completion pulse
- ZERO  out  1  RESULT==0, registered with RESULT
- ERR  out  1  last operation had an illegal OPCODE; updated with RESULT

## Operation
States:
- IDLE
  - START=1 captures OPCODE, DATA1, DATA2 into working registers and computes the step count n.
  - If n>0 → RUN; if n=0 → FIN.
- RUN: one step per cycle, n decrements; goes to FIN after the step that takes n to 0.
- FIN: loads RESULT/ZERO/ERR from the working register, DONE=1, returns to IDLE.

Step count n:
- SLL/SRL/SRA: n = min(DATA2, 8).
- ROR: n = DATA2 mod 8.
- MUL: n = 8.
- Illegal opcode: n = 0.

Per-step behaviour:
- SLL: acc = {acc[6:0],0}.
- SRL: acc = {0,acc[7:1]}.
- SRA: acc = {acc[7],acc[7:1]}.
- ROR: acc = {acc[0],acc[7:1]}.
- MUL (shift-add over multiplier bits LSB first, mod 256): if mplr[0], prod += mcand; then mcand <<= 1 and mplr >>= 1.

Resulting values:
- Counts ≥8 saturate: SLL/SRL give 0x00; SRA gives 0x00 or 0xFF by sign.
- MUL result is the low 8 bits of the unsigned product.
- Illegal opcode: RESULT=DATA1, ERR=1. ERR=0 for all legal ops.

Handshake and input rules:
- Operands and OPCODE are ignored after the capture edge.
- START while BUSY=1 is ignored; it is neither queued nor errored.
- START asserted during the DONE cycle (BUSY=0) is accepted, so back-to-back operations are possible.

## Timing
Reset:
- Any edge with RESET=0 → IDLE.
- Outputs after reset: RESULT=0x00, ZERO=1, ERR=0, BUSY=0, DONE=0.
- Working registers are cleared; an in-flight operation is discarded and produces no DONE.
- Reset has priority over START.

Latency, with START captured at edge k:
- BUSY=1 from edge k to edge k+n+1.
- At edge k+n+1: RESULT/ZERO/ERR update, DONE=1, BUSY=0.
- DONE falls at edge k+n+2 unless a new operation completes then.

Latency figures:
- n=0 (count 0, ROR by multiple of 8, illegal): DONE one cycle after capture.
- MUL: always 9 cycles.
- Shift/rotate: at most 9 cycles.

Invariants:
- BUSY and DONE are never both 1.
- RESULT is stable whenever DONE=0.

## Test plan
- Reset, then SLL with DATA1=0x81, DATA2=3 → DONE 4 cycles after capture, RESULT=0x08, ZERO=0, ERR=0. An SRL that follows in the DONE cycle (DATA1=0x81, DATA2=7) → RESULT=0x01.
- SRA with DATA1=0x90, DATA2=2 → RESULT=0xE4 after 3 cycles. SRA with 0x90 by 200 → RESULT=0xFF after 9 cycles (saturated n=8). SRL with 0x90 by 9 → RESULT=0x00, ZERO=1.
- ROR with 0x01 by 1 → 0x80. ROR with 0x01 by 9 → 0x80 in 2 cycles. ROR with 0xA5 by 8 → 0xA5 with DONE 1 cycle after capture.
- MUL 0x0F×0x11 → 0xFF after 9 cycles. MUL 0x10×0x10 → 0x00, ZERO=1. Change DATA1/DATA2 and pulse START mid-operation → no effect on RESULT or timing.
- RESET=0 at the 4th RUN cycle of MUL 0x07×0x03 → next cycle BUSY=0, DONE=0, RESULT=0x00, ZERO=1, and DONE never pulses. A fresh MUL 0x07×0x03 afterwards → 0x15.
- OPCODE=111, DATA1=0x3C → DONE after 1 cycle, RESULT=0x3C, ERR=1. A following legal SLL 0x3C by 0 → RESULT=0x3C, ERR=0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for shift, rotate and multiply ops of the 8-bit CPU.
// Takes one op per START handshake, performs one bit-step per clock, then pulses DONE.
module alu_seq_ctrl (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [2:0] OPCODE,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ZERO,
  output logic       ERR
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    mplr_q, mplr_d;
  logic            ill_q, ill_d;
  logic [W-1:0]    result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next-state, datapath step and output update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    ill_d    = ill_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d    = OPCODE;
          acc_d   = DATA1;
          mcand_d = DATA1;
          mplr_d  = DATA2;
          ill_d   = 1'b0;
          case (OPCODE)
            OP_SLL, OP_SRL, OP_SRA: cnt_d = (DATA2 >= 8'd8) ? CW'(8) : CW'(DATA2);
            OP_ROR:                 cnt_d = {1'b0, DATA2[2:0]};
            OP_MUL: begin
              cnt_d = CW'(8);
              acc_d = '0;
            end
            default: begin
              cnt_d = '0;
              ill_d = 1'b1;
            end
          endcase
          state_d = (cnt_d == '0) ? S_FIN : S_RUN;
        end
      end

      S_RUN: begin
        case (op_q)
          OP_SLL: acc_d = {acc_q[W-2:0], 1'b0};
          OP_SRL: acc_d = {1'b0, acc_q[W-1:1]};
          OP_SRA: acc_d = {acc_q[W-1], acc_q[W-1:1]};
          OP_ROR: acc_d = {acc_q[0], acc_q[W-1:1]};
          OP_MUL: begin
            if (mplr_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = {mcand_q[W-2:0], 1'b0};
            mplr_d  = {1'b0, mplr_q[W-1:1]};
          end
          default: acc_d = acc_q;
        endcase
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIN;
      end

      S_FIN: begin
        result_d = acc_q;
        zero_d   = (acc_q == '0);
        err_d    = ill_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      ill_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      ill_q    <= ill_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign RESULT = result_q;
  assign ZERO   = zero_q;
  assign ERR    = err_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl: latency, results, flags,
// back-to-back handshakes, mid-operation reset and ignored START while busy.
module tb_alu_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [2:0] OPCODE;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;
  logic       ZERO;
  logic       ERR;

  int checks = 0;
  int errors = 0;

  int   lat;
  logic busy_at_cap;
  logic done_at_cap;
  int   inv_bad = 0;
  int   res_moved = 0;

  localparam logic [2:0] SLL = 3'b000;
  localparam logic [2:0] SRL = 3'b001;
  localparam logic [2:0] SRA = 3'b010;
  localparam logic [2:0] ROR = 3'b011;
  localparam logic [2:0] MUL = 3'b100;

  alu_seq_ctrl dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .OPCODE (OPCODE),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .RESULT (RESULT),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ZERO   (ZERO),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  // Issue one op from a point away from the clock edge; returns edges from
  // capture to DONE in lat (-1 on timeout). Optionally disturbs inputs mid-run.
  task automatic do_op(input logic [2:0] op, input logic [7:0] d1,
                       input logic [7:0] d2, input bit disturb);
    logic [7:0] prev;
    prev   = RESULT;
    START  = 1'b1;
    OPCODE = op;
    DATA1  = d1;
    DATA2  = d2;
    @(posedge CLK);
    #1;
    START       = 1'b0;
    busy_at_cap = BUSY;
    done_at_cap = DONE;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      if (disturb && i < 5) begin
        START  = 1'b1;
        OPCODE = ROR;
        DATA1  = 8'($urandom);
        DATA2  = 8'($urandom);
      end else begin
        START = 1'b0;
      end
      @(posedge CLK);
      #1;
      if (BUSY && DONE) inv_bad++;
      if (DONE) begin
        lat = i;
        break;
      end
      if (RESULT !== prev) res_moved++;
    end
    START = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    START = 1'b1;
    OPCODE = MUL;
    DATA1 = 8'h12;
    DATA2 = 8'h34;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if (DONE !== 1'b0)     begin errors++; $display("FAIL reset_done got %b exp 0", DONE); end
    checks++; if (RESULT !== 8'h00)  begin errors++; $display("FAIL reset_result got %h exp 00", RESULT); end
    checks++; if (ZERO !== 1'b1)     begin errors++; $display("FAIL reset_zero got %b exp 1", ZERO); end
    checks++; if (ERR !== 1'b0)      begin errors++; $display("FAIL reset_err got %b exp 0", ERR); end
    START = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_sll_srl_back_to_back;
    do_op(SLL, 8'h81, 8'd3, 1'b0);
    checks++; if (lat !== 4)          begin errors++; $display("FAIL sll_lat got %0d exp 4", lat); end
    checks++; if (RESULT !== 8'h08)   begin errors++; $display("FAIL sll_result got %h exp 08", RESULT); end
    checks++; if (ZERO !== 1'b0)      begin errors++; $display("FAIL sll_zero got %b exp 0", ZERO); end
    checks++; if (ERR !== 1'b0)       begin errors++; $display("FAIL sll_err got %b exp 0", ERR); end
    checks++; if (BUSY !== 1'b0)      begin errors++; $display("FAIL sll_busy_at_done got %b exp 0", BUSY); end
    // Issued in the DONE cycle.
    do_op(SRL, 8'h81, 8'd7, 1'b0);
    checks++; if (busy_at_cap !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy_at_cap); end
    checks++; if (done_at_cap !== 1'b0) begin errors++; $display("FAIL b2b_done_fall got %b exp 0", done_at_cap); end
    checks++; if (lat !== 8)          begin errors++; $display("FAIL srl_lat got %0d exp 8", lat); end
    checks++; if (RESULT !== 8'h01)   begin errors++; $display("FAIL srl_result got %h exp 01", RESULT); end
  endtask

  task automatic test_sra_saturate;
    do_op(SRA, 8'h90, 8'd2, 1'b0);
    checks++; if (lat !== 3)          begin errors++; $display("FAIL sra2_lat got %0d exp 3", lat); end
    checks++; if (RESULT !== 8'hE4)   begin errors++; $display("FAIL sra2_result got %h exp e4", RESULT); end
    do_op(SRA, 8'h90, 8'd200, 1'b0);
    checks++; if (lat !== 9)          begin errors++; $display("FAIL sra200_lat got %0d exp 9", lat); end
    checks++; if (RESULT !== 8'hFF)   begin errors++; $display("FAIL sra200_result got %h exp ff", RESULT); end
    do_op(SRL, 8'h90, 8'd9, 1'b0);
    checks++; if (lat !== 9)          begin errors++; $display("FAIL srl9_lat got %0d exp 9", lat); end
    checks++; if (RESULT !== 8'h00)   begin errors++; $display("FAIL srl9_result got %h exp 00", RESULT); end
    checks++; if (ZERO !== 1'b1)      begin errors++; $display("FAIL srl9_zero got %b exp 1", ZERO); end
  endtask

  task automatic test_ror;
    do_op(ROR, 8'h01, 8'd1, 1'b0);
    checks++; if (lat !== 2)          begin errors++; $display("FAIL ror1_lat got %0d exp 2", lat); end
    checks++; if (RESULT !== 8'h80)   begin errors++; $display("FAIL ror1_result got %h exp 80", RESULT); end
    do_op(ROR, 8'h01, 8'd9, 1'b0);
    checks++; if (lat !== 2)          begin errors++; $display("FAIL ror9_lat got %0d exp 2", lat); end
    checks++; if (RESULT !== 8'h80)   begin errors++; $display("FAIL ror9_result got %h exp 80", RESULT); end
    do_op(ROR, 8'hA5, 8'd8, 1'b0);
    checks++; if (lat !== 1)          begin errors++; $display("FAIL ror8_lat got %0d exp 1", lat); end
    checks++; if (RESULT !== 8'hA5)   begin errors++; $display("FAIL ror8_result got %h exp a5", RESULT); end
  endtask

  task automatic test_mul;
    do_op(MUL, 8'h0F, 8'h11, 1'b0);
    checks++; if (lat !== 9)          begin errors++; $display("FAIL mul_ff_lat got %0d exp 9", lat); end
    checks++; if (RESULT !== 8'hFF)   begin errors++; $display("FAIL mul_ff_result got %h exp ff", RESULT); end
    do_op(MUL, 8'h10, 8'h10, 1'b0);
    checks++; if (RESULT !== 8'h00)   begin errors++; $display("FAIL mul_wrap_result got %h exp 00", RESULT); end
    checks++; if (ZERO !== 1'b1)      begin errors++; $display("FAIL mul_wrap_zero got %b exp 1", ZERO); end
    res_moved = 0;
    do_op(MUL, 8'h03, 8'h05, 1'b1);
    checks++; if (lat !== 9)          begin errors++; $display("FAIL mul_disturb_lat got %0d exp 9", lat); end
    checks++; if (RESULT !== 8'h0F)   begin errors++; $display("FAIL mul_disturb_result got %h exp 0f", RESULT); end
    checks++; if (res_moved !== 0)    begin errors++; $display("FAIL result_stable got %0d exp 0", res_moved); end
  endtask

  task automatic test_reset_mid_op;
    int dones;
    START  = 1'b1;
    OPCODE = MUL;
    DATA1  = 8'h07;
    DATA2  = 8'h03;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    checks++; if (BUSY !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b exp 0", BUSY); end
    checks++; if (DONE !== 1'b0)      begin errors++; $display("FAIL midrst_done got %b exp 0", DONE); end
    checks++; if (RESULT !== 8'h00)   begin errors++; $display("FAIL midrst_result got %h exp 00", RESULT); end
    checks++; if (ZERO !== 1'b1)      begin errors++; $display("FAIL midrst_zero got %b exp 1", ZERO); end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) dones++;
    end
    checks++; if (dones !== 0)        begin errors++; $display("FAIL midrst_no_done got %0d exp 0", dones); end
    do_op(MUL, 8'h07, 8'h03, 1'b0);
    checks++; if (lat !== 9)          begin errors++; $display("FAIL mul_fresh_lat got %0d exp 9", lat); end
    checks++; if (RESULT !== 8'h15)   begin errors++; $display("FAIL mul_fresh_result got %h exp 15", RESULT); end
  endtask

  task automatic test_illegal;
    @(posedge CLK);
    #1;
    do_op(3'b111, 8'h3C, 8'h55, 1'b0);
    checks++; if (lat !== 1)          begin errors++; $display("FAIL ill_lat got %0d exp 1", lat); end
    checks++; if (RESULT !== 8'h3C)   begin errors++; $display("FAIL ill_result got %h exp 3c", RESULT); end
    checks++; if (ERR !== 1'b1)       begin errors++; $display("FAIL ill_err got %b exp 1", ERR); end
    do_op(SLL, 8'h3C, 8'd0, 1'b0);
    checks++; if (lat !== 1)          begin errors++; $display("FAIL sll0_lat got %0d exp 1", lat); end
    checks++; if (RESULT !== 8'h3C)   begin errors++; $display("FAIL sll0_result got %h exp 3c", RESULT); end
    checks++; if (ERR !== 1'b0)       begin errors++; $display("FAIL sll0_err got %b exp 0", ERR); end
    checks++; if (inv_bad !== 0)      begin errors++; $display("FAIL busy_done_overlap got %0d exp 0", inv_bad); end
  endtask

  initial begin
    RESET  = 1'b0;
    START  = 1'b0;
    OPCODE = 3'b000;
    DATA1  = 8'h00;
    DATA2  = 8'h00;
    @(negedge CLK);
    test_reset();
    test_sll_srl_back_to_back();
    test_sra_saturate();
    test_ror();
    test_mul();
    test_reset_mid_op();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
